// File: rtl/arp_tbl_arbiter.sv
// ARP next-hop table arbiter: shares one 32x96 single-port RAM between software
// read/write and a linear lookup scan. Optional early scan exit: ARP_SCAN_EARLY_EXIT_EN.
module arp_tbl_arbiter #(
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic                              tbl_wr_req,
  input  logic [4:0]                        tbl_wr_addr,
  input  logic [3*C_S_AXI_DATA_WIDTH-1:0]   tbl_wr_data,
  output logic                              tbl_wr_ack,
  input  logic                              tbl_rd_req,
  input  logic [4:0]                        tbl_rd_addr,
  output logic [3*C_S_AXI_DATA_WIDTH-1:0]   tbl_rd_data,
  output logic                              tbl_rd_ack,
  input  logic                              lkp_req,
  input  logic [31:0]                       lkp_ip,
  output logic                              lkp_ready,
  output logic                              lkp_done,
  output logic                              lkp_hit,
  output logic [47:0]                       lkp_mac,
  output logic [4:0]                        lkp_idx,
  output logic                              mem_en,
  output logic                              mem_we,
  output logic [4:0]                        mem_addr,
  output logic [3*C_S_AXI_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [3*C_S_AXI_DATA_WIDTH-1:0]   mem_rdata,
  input  logic                              clear,
  output logic [31:0]                       lkp_miss_count
);
  localparam int ENT_W = 3*C_S_AXI_DATA_WIDTH;
`ifdef ARP_SCAN_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SW_WR, SW_RD, SW_RDW, SCAN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic               wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic [4:0]         wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [ENT_W-1:0]   wr_data_q, wr_data_d;
  logic [31:0]        ip_q, ip_d;
  logic               cmp_vld_q, cmp_vld_d;
  logic [4:0]         cmp_idx_q, cmp_idx_d;
  logic               found_q, found_d;
  logic [4:0]         found_idx_q, found_idx_d;
  logic [47:0]        found_mac_q, found_mac_d;
  logic               mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [4:0]         mem_addr_q, mem_addr_d;
  logic [ENT_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic               wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
  logic [ENT_W-1:0]   rd_data_q, rd_data_d;
  logic               done_q, done_d, hit_q, hit_d;
  logic [47:0]        mac_q, mac_d;
  logic [4:0]         idx_q, idx_d;
  logic [31:0]        miss_q, miss_d;
  logic               hit_s, scan_end_s, wr_taken_s, rd_taken_s;

  always_comb begin
    state_d     = state_q;
    ip_d        = ip_q;
    cmp_vld_d   = 1'b0;
    cmp_idx_d   = mem_addr_q;
    found_d     = found_q;
    found_idx_d = found_idx_q;
    found_mac_d = found_mac_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_ack_d    = 1'b0;
    rd_ack_d    = 1'b0;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    hit_d       = hit_q;
    mac_d       = mac_q;
    idx_d       = idx_q;
    miss_d      = miss_q;
    scan_end_s  = 1'b0;
    wr_taken_s  = 1'b0;
    rd_taken_s  = 1'b0;

    // Data returned for the address issued last cycle; IP 0 marks an empty slot.
    hit_s = cmp_vld_q && (state_q == SCAN || state_q == DRAIN) &&
            (mem_rdata[31:0] == ip_q) && (mem_rdata[31:0] != 32'd0);

    if (hit_s && !found_q) begin
      found_d     = 1'b1;
      found_idx_d = cmp_idx_q;
      found_mac_d = mem_rdata[79:32];
    end else begin
      found_d = found_q;
    end

    case (state_q)
      IDLE: begin
        if (wr_pend_q) begin
          state_d     = SW_WR;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr_q;
          mem_wdata_d = wr_data_q;
          wr_taken_s  = 1'b1;
        end else if (rd_pend_q) begin
          state_d    = SW_RD;
          mem_en_d   = 1'b1;
          mem_addr_d = rd_addr_q;
          rd_taken_s = 1'b1;
        end else if (lkp_req) begin
          state_d    = SCAN;
          mem_en_d   = 1'b1;
          mem_addr_d = 5'd0;
          ip_d       = lkp_ip;
          found_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SW_WR: begin
        wr_ack_d = 1'b1;
        state_d  = IDLE;
      end
      SW_RD: state_d = SW_RDW;
      SW_RDW: begin
        rd_data_d = mem_rdata;
        rd_ack_d  = 1'b1;
        state_d   = IDLE;
      end
      SCAN: begin
        cmp_vld_d = 1'b1;
        if (EARLY_EXIT && hit_s) begin
          scan_end_s = 1'b1;
          state_d    = IDLE;
        end else if (mem_addr_q == 5'd31) begin
          state_d = DRAIN;
        end else begin
          mem_en_d   = 1'b1;
          mem_addr_d = mem_addr_q + 5'd1;
        end
      end
      DRAIN: begin
        scan_end_s = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A hit recorded earlier in the scan always wins over the current compare.
    if (scan_end_s) begin
      done_d = 1'b1;
      if (found_q) begin
        hit_d = 1'b1;
        idx_d = found_idx_q;
        mac_d = found_mac_q;
      end else if (hit_s) begin
        hit_d = 1'b1;
        idx_d = cmp_idx_q;
        mac_d = mem_rdata[79:32];
      end else begin
        hit_d  = 1'b0;
        idx_d  = 5'd0;
        mac_d  = 48'd0;
        miss_d = miss_q + 32'd1;
      end
    end else begin
      done_d = 1'b0;
    end

    if (clear) begin
      miss_d = 32'd0;
    end else begin
      miss_d = miss_d;
    end

    // A fresh pulse overrides both a stale pending entry and its consumption.
    if (tbl_wr_req) begin
      wr_pend_d = 1'b1;
      wr_addr_d = tbl_wr_addr;
      wr_data_d = tbl_wr_data;
    end else begin
      wr_pend_d = wr_pend_q & ~wr_taken_s;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
    if (tbl_rd_req) begin
      rd_pend_d = 1'b1;
      rd_addr_d = tbl_rd_addr;
    end else begin
      rd_pend_d = rd_pend_q & ~rd_taken_s;
      rd_addr_d = rd_addr_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state_q     <= IDLE;
      wr_pend_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_addr_q   <= 5'd0;
      rd_addr_q   <= 5'd0;
      wr_data_q   <= '0;
      ip_q        <= 32'd0;
      cmp_vld_q   <= 1'b0;
      cmp_idx_q   <= 5'd0;
      found_q     <= 1'b0;
      found_idx_q <= 5'd0;
      found_mac_q <= 48'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 5'd0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      mac_q       <= 48'd0;
      idx_q       <= 5'd0;
      miss_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      wr_pend_q   <= wr_pend_d;
      rd_pend_q   <= rd_pend_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      wr_data_q   <= wr_data_d;
      ip_q        <= ip_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_idx_q   <= cmp_idx_d;
      found_q     <= found_d;
      found_idx_q <= found_idx_d;
      found_mac_q <= found_mac_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
      rd_ack_q    <= rd_ack_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      mac_q       <= mac_d;
      idx_q       <= idx_d;
      miss_q      <= miss_d;
    end
  end

  assign lkp_ready      = (state_q == IDLE) & ~wr_pend_q & ~rd_pend_q;
  assign tbl_wr_ack     = wr_ack_q;
  assign tbl_rd_ack     = rd_ack_q;
  assign tbl_rd_data    = rd_data_q;
  assign lkp_done       = done_q;
  assign lkp_hit        = hit_q;
  assign lkp_mac        = mac_q;
  assign lkp_idx        = idx_q;
  assign mem_en         = mem_en_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign lkp_miss_count = miss_q;
endmodule

// File: tb/tb_arp_tbl_arbiter.sv
// Directed, table-driven bench for arp_tbl_arbiter with a behavioural 32x96 RAM;
// expected lookup latency follows ARP_SCAN_EARLY_EXIT_EN.
module tb_arp_tbl_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0, lreq = 1'b0, clr = 1'b0;
  logic [4:0]  wr_addr = 5'd0, rd_addr = 5'd0;
  logic [95:0] wr_data = 96'd0;
  logic [31:0] lip = 32'd0;
  logic        wr_ack, rd_ack, lready, ldone, lhit, men, mwe;
  logic [95:0] rd_data, mwdata, mrdata;
  logic [47:0] lmac;
  logic [4:0]  lidx, maddr;
  logic [31:0] miss_cnt;
  logic [95:0] ram [32];

  int n_checks = 0;
  int n_fail   = 0;

  arp_tbl_arbiter #(.C_S_AXI_DATA_WIDTH(32)) dut (
    .AXI_ACLK(clk), .AXI_RESET(rst),
    .tbl_wr_req(wr_req), .tbl_wr_addr(wr_addr), .tbl_wr_data(wr_data), .tbl_wr_ack(wr_ack),
    .tbl_rd_req(rd_req), .tbl_rd_addr(rd_addr), .tbl_rd_data(rd_data), .tbl_rd_ack(rd_ack),
    .lkp_req(lreq), .lkp_ip(lip), .lkp_ready(lready),
    .lkp_done(ldone), .lkp_hit(lhit), .lkp_mac(lmac), .lkp_idx(lidx),
    .mem_en(men), .mem_we(mwe), .mem_addr(maddr), .mem_wdata(mwdata), .mem_rdata(mrdata),
    .clear(clr), .lkp_miss_count(miss_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (men) begin
      if (mwe) ram[maddr] <= mwdata;
      else     mrdata <= ram[maddr];
    end
  end

  typedef struct {
    int          op;      // 0 write, 1 read, 2 lookup
    logic [4:0]  addr;
    logic [95:0] data;    // write data / expected read data / lookup IP in [31:0]
    logic        exp_hit;
    logic [4:0]  exp_idx;
    logic [47:0] exp_mac;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  function automatic int scan_lat(input int k);
`ifdef ARP_SCAN_EARLY_EXIT_EN
    return 3 + k;
`else
    return 34 + 0*k;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [95:0] d, output int lat);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_req = 1'b0;
    lat = 1;
    while (!wr_ack && lat < 20) begin tick(); lat++; end
  endtask

  task automatic do_read(input logic [4:0] a, output logic [95:0] d, output int lat);
    rd_req = 1'b1; rd_addr = a;
    tick();
    rd_req = 1'b0;
    lat = 1;
    while (!rd_ack && lat < 20) begin tick(); lat++; end
    d = rd_data;
  endtask

  task automatic do_lookup(input logic [31:0] ip, output int lat);
    lreq = 1'b1; lip = ip;
    tick();
    lreq = 1'b0;
    lat = 1;
    while (!ldone && lat < 60) begin tick(); lat++; end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ctl"}, {90'd0, wr_ack, rd_ack, ldone, lhit, men, mwe}, 96'd0);
    chk({tag, "_rd_data"}, rd_data, 96'd0);
    chk({tag, "_mac_idx_addr"}, {38'd0, lmac, lidx, maddr}, 96'd0);
    chk({tag, "_wdata"}, mwdata, 96'd0);
    chk({tag, "_miss"}, {64'd0, miss_cnt}, 96'd0);
    chk({tag, "_ready"}, {95'd0, lready}, 96'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [95:0] e3, e7, e10, e31, a5, b5, rdv;
    int lat, dc, wc, rc, wn, dn, base;
    e3  = {16'h0000, 48'h0011_2233_4455, 32'h0A00_0001};
    e7  = {16'hBEEF, 48'hAABB_CCDD_EEFF, 32'h0A00_0001};
    e10 = {16'h1234, 48'h0000_0000_0A0A, 32'hC0A8_0001};
    e31 = {16'h0000, 48'h1234_5678_9ABC, 32'hFFFF_FFFF};
    a5  = {16'h0000, 48'h0101_0101_0101, 32'h0505_0505};
    b5  = {16'h5555, 48'h0202_0202_0202, 32'h0606_0606};
    for (int i = 0; i < 32; i++) ram[i] = 96'd0;
    mrdata = 96'd0;

    vecs[0]  = '{0, 5'd3,  e3,  1'b0, 5'd0,  48'd0, 3};
    vecs[1]  = '{1, 5'd3,  e3,  1'b0, 5'd0,  48'd0, 4};
    vecs[2]  = '{0, 5'd7,  e7,  1'b0, 5'd0,  48'd0, 3};
    vecs[3]  = '{0, 5'd10, e10, 1'b0, 5'd0,  48'd0, 3};
    vecs[4]  = '{0, 5'd31, e31, 1'b0, 5'd0,  48'd0, 3};
    vecs[5]  = '{1, 5'd7,  e7,  1'b0, 5'd0,  48'd0, 4};
    vecs[6]  = '{2, 5'd0, {64'd0, 32'h0A00_0001}, 1'b1, 5'd3,  48'h0011_2233_4455, scan_lat(3)};
    vecs[7]  = '{2, 5'd0, {64'd0, 32'hC0A8_0001}, 1'b1, 5'd10, 48'h0000_0000_0A0A, scan_lat(10)};
    vecs[8]  = '{2, 5'd0, {64'd0, 32'hFFFF_FFFF}, 1'b1, 5'd31, 48'h1234_5678_9ABC, 34};
    vecs[9]  = '{2, 5'd0, {64'd0, 32'h0A00_00FF}, 1'b0, 5'd0,  48'd0, 34};
    vecs[10] = '{2, 5'd0, {64'd0, 32'h0000_0000}, 1'b0, 5'd0,  48'd0, 34};

    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk_reset_state("reset");

    for (int i = 0; i < 11; i++) begin
      case (vecs[i].op)
        0: begin
          do_write(vecs[i].addr, vecs[i].data, lat);
          chk($sformatf("v%0d_wr_lat", i), lat, vecs[i].exp_lat);
        end
        1: begin
          do_read(vecs[i].addr, rdv, lat);
          chk($sformatf("v%0d_rd_data", i), rdv, vecs[i].data);
          chk($sformatf("v%0d_rd_lat", i), lat, vecs[i].exp_lat);
        end
        2: begin
          chk($sformatf("v%0d_ready", i), {95'd0, lready}, 96'd1);
          do_lookup(vecs[i].data[31:0], lat);
          chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
          chk($sformatf("v%0d_hit", i), {95'd0, lhit}, {95'd0, vecs[i].exp_hit});
          chk($sformatf("v%0d_idx", i), {91'd0, lidx}, {91'd0, vecs[i].exp_idx});
          chk($sformatf("v%0d_mac", i), {48'd0, lmac}, {48'd0, vecs[i].exp_mac});
        end
        default: ;
      endcase
      tick();
    end
    chk("miss_count_2", {64'd0, miss_cnt}, 96'd2);

    // Clear coincides with the miss increment of a third lookup.
    lreq = 1'b1; lip = 32'h0A00_00FF;
    tick();
    lreq = 1'b0;
    repeat (32) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_done", {95'd0, ldone}, 96'd1);
    chk("clr_count", {64'd0, miss_cnt}, 96'd0);
    tick();
    chk("done_pulse", {95'd0, ldone}, 96'd0);

    // Software write/read to addr 5 queued behind an active scan; second write overrides.
    lreq = 1'b1; lip = 32'h0A00_0001;
    tick();
    lreq = 1'b0;
    tick();
    wr_req = 1'b1; wr_addr = 5'd5; wr_data = a5;
    tick();
    wr_data = b5; rd_req = 1'b1; rd_addr = 5'd5;
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    chk("scan_ready_low", {95'd0, lready}, 96'd0);
    dc = -1; wc = -1; rc = -1; wn = 0; dn = 0; rdv = 96'd0;
    for (int c = 4; c < 80; c++) begin
      if (ldone) begin dc = c; dn++; end
      if (wr_ack) begin wc = c; wn++; end
      if (rd_ack) begin rc = c; rdv = rd_data; end
      tick();
    end
    base = scan_lat(3);
    chk("q_done_cyc", dc, base);
    chk("q_done_n", dn, 1);
    chk("q_wr_cyc", wc, base + 2);
    chk("q_wr_n", wn, 1);
    chk("q_rd_cyc", rc, base + 5);
    chk("q_rd_data", rdv, b5);
    chk("q_held_hit", {90'd0, lhit, lidx}, {90'd0, 1'b1, 5'd3});
    chk("q_ready_after", {95'd0, lready}, 96'd1);

    // Reset in the middle of a scan aborts it without a result.
    lreq = 1'b1; lip = 32'h0A00_0001;
    tick();
    lreq = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("abort");
    dn = 0;
    for (int c = 0; c < 50; c++) begin
      if (ldone) dn++;
      tick();
    end
    chk("abort_no_done", dn, 0);
    do_read(5'd3, rdv, lat);
    chk("abort_ram_kept", rdv, e3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/arp_tbl_arbiter.md
ARP_TBL_ARBITER -- requirements
Module: arp_tbl_arbiter

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, register data width; table entry width is 3*C_S_AXI_DATA_WIDTH (96).
REQ-002 SHALL have port AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port AXI_RESET  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports tbl_wr_req in 1, tbl_wr_addr in 5, tbl_wr_data in 96, tbl_wr_ack out 1: software write, single-cycle request pulse, single-cycle ack pulse.
REQ-005 SHALL have ports tbl_rd_req in 1, tbl_rd_addr in 5, tbl_rd_data out 96, tbl_rd_ack out 1: software read, same pulse semantics.
REQ-006 SHALL have ports lkp_req in 1, lkp_ip in 32, lkp_ready out 1: datapath next-hop lookup request, accepted when lkp_req & lkp_ready.
REQ-007 SHALL have ports lkp_done out 1, lkp_hit out 1, lkp_mac out 48, lkp_idx out 5: lookup result, valid only while lkp_done is high.
REQ-008 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out 5, mem_wdata out 96, mem_rdata in 96: single-port 32x96 table RAM, read data valid the cycle after mem_en & !mem_we.
REQ-009 SHALL have ports clear in 1 (counter clear) and lkp_miss_count out 32.

Function
REQ-010 Entry format SHALL be [31:0] IPv4 next hop, [79:32] MAC, [95:80] ignored; entry with IP 0 SHALL never hit.
REQ-011 States SHALL be IDLE, SW_WR, SW_RD, SW_RDW, SCAN, DRAIN; exactly one RAM access per cycle.
REQ-012 A request pulse SHALL be latched into a pending register (addr/data) in any state; a second pulse of the same kind before service SHALL overwrite the pending contents.
REQ-013 In IDLE, priority SHALL be pending write > pending read > lkp_req; lkp_ready = (state==IDLE) & no pending software request.
REQ-014 SW_WR: one cycle, mem_en=mem_we=1; tbl_wr_ack high the following cycle; return to IDLE.
REQ-015 SW_RD issues read; SW_RDW captures mem_rdata into tbl_rd_data and pulses tbl_rd_ack the following cycle (ack two cycles after SW_RD entry).
REQ-016 Simultaneous rd and wr pulses SHALL both be serviced, write first; read of the same address returns the new data.
REQ-017 Lookup accepted at cycle T: lkp_ip registered; SCAN issues addresses 0..31 in cycles T+1..T+32; each returned entry compared the cycle after issue (DRAIN covers the last compare).
REQ-018 Result SHALL report the lowest-index matching entry; lkp_done pulses one cycle; lkp_hit/lkp_mac/lkp_idx held until the next lkp_done; on miss lkp_mac=0, lkp_idx=0.
REQ-019 Software requests arriving during SCAN/DRAIN SHALL wait (not preempt); serviced on return to IDLE before any new lookup.
REQ-020 lkp_miss_count SHALL increment by 1 per miss, wrap 0xFFFFFFFF->0; clear has priority over a same-cycle increment.

Reset
REQ-021 On AXI_RESET: state IDLE, pending cleared, all acks/lkp_done/lkp_hit/mem_en/mem_we 0, tbl_rd_data/lkp_mac/lkp_idx/mem_addr/mem_wdata 0, lkp_miss_count 0; lkp_ready 1 first cycle after reset.
REQ-022 Reset mid-SCAN or mid-SW_RD SHALL abort with no lkp_done/tbl_rd_ack ever issued for the aborted operation; RAM contents untouched.

Configuration
REQ-023 Macro ARP_SCAN_EARLY_EXIT_EN defined: scan SHALL stop at first hit on entry k, lkp_done at T+3+k; misses still at T+34.
REQ-024 Macro undefined: every lookup SHALL scan all 32 entries, lkp_done at exactly T+34, result still lowest-index match.

Verification
REQ-025 Write addr 3 = {16'h0, 48'h0011_2233_4455, 32'h0A00_0001}, then read addr 3 -> tbl_wr_ack 1 cycle after SW_WR, tbl_rd_data equal to written value, ack 2 cycles after SW_RD.
REQ-026 Entries 3 and 7 both IP 0x0A000001, lookup 0x0A000001 at T -> lkp_hit=1, lkp_idx=3, lkp_mac=0x001122334455, done at T+6 (early exit) or T+34 (no early exit).
REQ-027 Lookup 0x0A0000FF (absent), then lookup 0x00000000 -> two misses, lkp_miss_count=2; clear asserted same cycle as a third miss -> count 0.
REQ-028 tbl_rd_req and tbl_wr_req same cycle, same addr 5, during an active SCAN -> lkp_ready low, scan completes, write then read serviced, read returns new data, lkp_ready high afterwards.
REQ-029 AXI_RESET asserted at T+10 of a scan -> no lkp_done, all outputs at reset values next cycle, lkp_ready high, prior table contents readable.
